// File: rtl/logic_gate_unit_if.sv
// Streaming handshake bundle for logic_gate_unit: valid/ready input beat
// with operands and control, valid/ready output with result and status.
interface logic_gate_unit_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             mode;
  logic             last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             y_any;
  logic             y_all;
  logic [CNT_W-1:0] beats;
  logic             err;

  modport master (
    output in_valid, a, b, op, mode, last, out_ready,
    input  in_ready, out_valid, y, y_any, y_all, beats, err
  );

  modport slave (
    input  in_valid, a, b, op, mode, last, out_ready,
    output in_ready, out_valid, y, y_any, y_all, beats, err
  );
endinterface

// File: rtl/logic_gate_unit.sv
// Registered bitwise gate engine: per-beat pairwise gates or a gate folded
// across a multi-beat frame, with valid/ready on both sides.
module logic_gate_unit #(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16,
  parameter int CNT_W     = $clog2(MAX_BEATS + 1)
) (
  input logic             clk,
  input logic             rst_n,
  logic_gate_unit_if.slave gif
);
  localparam logic [2:0] OP_OR   = 3'd0;
  localparam logic [2:0] OP_AND  = 3'd1;
  localparam logic [2:0] OP_NOTA = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_NAND = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_XNOR = 3'd6;
  localparam logic [2:0] OP_BUFA = 3'd7;

  typedef enum logic {S_IDLE, S_ACCUM} state_t;

  state_t           state_q;
  logic [2:0]       frame_op_q;
  logic [WIDTH-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] y_q;
  logic [CNT_W-1:0] beats_q;
  logic             err_q;
  logic             out_valid_q;

  logic             in_ready;
  logic             accept;
  logic             in_frame;
  logic [2:0]       eff_op;
  logic [WIDTH-1:0] pair_y;
  logic [WIDTH-1:0] acc_d;
  logic [CNT_W-1:0] cnt_d;
  logic             close;
  logic [WIDTH-1:0] emit_y;

  assign in_ready = !out_valid_q || gif.out_ready;
  assign accept   = gif.in_valid && in_ready;
  // An open frame swallows every beat until it closes, whatever mode says.
  assign in_frame = (state_q == S_ACCUM) || gif.mode;
  assign eff_op   = (state_q == S_ACCUM) ? frame_op_q : gif.op;

  always_comb begin
    pair_y = gif.a;
    case (gif.op)
      OP_OR:   pair_y = gif.a | gif.b;
      OP_AND:  pair_y = gif.a & gif.b;
      OP_NOTA: pair_y = ~gif.a;
      OP_NOR:  pair_y = ~(gif.a | gif.b);
      OP_NAND: pair_y = ~(gif.a & gif.b);
      OP_XOR:  pair_y = gif.a ^ gif.b;
      OP_XNOR: pair_y = ~(gif.a ^ gif.b);
      OP_BUFA: pair_y = gif.a;
      default: pair_y = gif.a;
    endcase
  end

  always_comb begin
    acc_d = gif.a;
    cnt_d = CNT_W'(1);
    if (state_q == S_ACCUM) begin
      cnt_d = cnt_q + CNT_W'(1);
      case (frame_op_q)
        OP_OR,  OP_NOR:  acc_d = acc_q | gif.a;
        OP_AND, OP_NAND: acc_d = acc_q & gif.a;
        OP_XOR, OP_XNOR: acc_d = acc_q ^ gif.a;
        default:         acc_d = gif.a;
      endcase
    end
    close = gif.last || (cnt_d == CNT_W'(MAX_BEATS));
    case (eff_op)
      OP_NOR, OP_NAND, OP_XNOR, OP_NOTA: emit_y = ~acc_d;
      default:                           emit_y = acc_d;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      frame_op_q  <= 3'd0;
      acc_q       <= '0;
      cnt_q       <= '0;
      y_q         <= '0;
      beats_q     <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (accept) begin
      if (!in_frame) begin
        y_q         <= pair_y;
        beats_q     <= CNT_W'(1);
        err_q       <= 1'b0;
        out_valid_q <= 1'b1;
      end else begin
        if (state_q == S_IDLE) frame_op_q <= gif.op;
        acc_q <= acc_d;
        cnt_q <= cnt_d;
        if (close) begin
          state_q     <= S_IDLE;
          y_q         <= emit_y;
          beats_q     <= cnt_d;
          err_q       <= !gif.last;
          out_valid_q <= 1'b1;
        end else begin
          state_q <= S_ACCUM;
          if (gif.out_ready) out_valid_q <= 1'b0;
        end
      end
    end else if (gif.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign gif.in_ready  = in_ready;
  assign gif.out_valid = out_valid_q;
  assign gif.y         = y_q;
  assign gif.y_any     = |y_q;
  assign gif.y_all     = &y_q;
  assign gif.beats     = beats_q;
  assign gif.err       = err_q;
endmodule

// File: tb/tb_logic_gate_unit.sv
// Bench for logic_gate_unit (WIDTH=8, MAX_BEATS=4): directed scenarios plus a
// randomized run scored against a frame-level reference model.
module tb_logic_gate_unit;
  localparam int WIDTH     = 8;
  localparam int MAX_BEATS = 4;
  localparam int CNT_W     = $clog2(MAX_BEATS + 1);

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  logic_gate_unit_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  logic_gate_unit #(.WIDTH(WIDTH), .MAX_BEATS(MAX_BEATS), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .gif   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [7:0] m_y;
  logic       m_ov;
  int         m_beats;
  logic       m_err;
  logic       m_open;
  logic [2:0] m_fop;
  logic [7:0] fq[$];

  function automatic logic [7:0] pair_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0: return a | b;
      3'd1: return a & b;
      3'd2: return ~a;
      3'd3: return ~(a | b);
      3'd4: return ~(a & b);
      3'd5: return a ^ b;
      3'd6: return ~(a ^ b);
      default: return a;
    endcase
  endfunction

  function automatic logic [7:0] frame_f();
    logic [7:0] r;
    case (m_fop)
      3'd0, 3'd3: begin r = 8'h00; foreach (fq[i]) r = r | fq[i]; end
      3'd1, 3'd4: begin r = 8'hFF; foreach (fq[i]) r = r & fq[i]; end
      3'd5, 3'd6: begin r = 8'h00; foreach (fq[i]) r = r ^ fq[i]; end
      default:    r = fq[fq.size()-1];
    endcase
    if (m_fop == 3'd2 || m_fop == 3'd3 || m_fop == 3'd4 || m_fop == 3'd6) r = ~r;
    return r;
  endfunction

  task automatic model_edge(input logic iv, input logic [7:0] ia, input logic [7:0] ib,
                            input logic [2:0] iop, input logic imode, input logic ilast,
                            input logic ior);
    logic loaded;
    loaded = 1'b0;
    if (iv && (!m_ov || ior)) begin
      if (!m_open && !imode) begin
        m_y = pair_f(iop, ia, ib); m_beats = 1; m_err = 1'b0; loaded = 1'b1;
      end else begin
        if (!m_open) begin m_open = 1'b1; m_fop = iop; fq.delete(); end
        fq.push_back(ia);
        if (ilast || fq.size() == MAX_BEATS) begin
          m_y = frame_f(); m_beats = fq.size(); m_err = !ilast; loaded = 1'b1; m_open = 1'b0;
        end
      end
    end
    if (loaded) m_ov = 1'b1;
    else if (ior) m_ov = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] op, input logic mode, input logic last);
    bus.in_valid = v; bus.a = a; bus.b = b; bus.op = op; bus.mode = mode; bus.last = last;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b1, 8'($urandom), 8'($urandom), 3'd0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.y !== 8'h00) begin bad++; $display("FAIL reset_y got=%h exp=00", bus.y); end
    total++; if (bus.y_all !== 1'b0 || bus.y_any !== 1'b0) begin bad++; $display("FAIL reset_any_all got=%b%b exp=00", bus.y_any, bus.y_all); end
    total++; if (bus.beats !== '0 || bus.err !== 1'b0) begin bad++; $display("FAIL reset_beats_err got=%0d/%b exp=0/0", bus.beats, bus.err); end
    drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    total++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_release got in_ready=%b out_valid=%b exp 1/0", bus.in_ready, bus.out_valid); end
  endtask

  task automatic test_pairwise_sweep();
    logic [7:0] exp_tab [8];
    exp_tab = '{8'hFF, 8'h00, 8'h3A, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'hC5};
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 8'hC5, 8'h3A, 3'(k), 1'b0, 1'b0);
      step();
      total++;
      if (bus.out_valid !== 1'b1 || bus.y !== exp_tab[k] || bus.beats !== CNT_W'(1) || bus.err !== 1'b0) begin
        bad++; $display("FAIL pairwise_op%0d got v=%b y=%h beats=%0d err=%b exp v=1 y=%h beats=1 err=0",
                        k, bus.out_valid, bus.y, bus.beats, bus.err, exp_tab[k]);
      end
    end
    drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    step();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL pairwise_drain got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_accum_xnor();
    logic [7:0] av [3];
    av = '{8'h0F, 8'hF0, 8'h01};
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, av[k], 8'h55, (k == 0) ? 3'd6 : 3'd1, 1'b1, k == 2);
      step();
      if (k < 2) begin
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL xnor_early_valid beat%0d got=%b exp=0", k, bus.out_valid); end
      end
    end
    total++;
    if (bus.out_valid !== 1'b1 || bus.y !== 8'h01 || bus.beats !== CNT_W'(3) || bus.err !== 1'b0) begin
      bad++; $display("FAIL xnor_result got v=%b y=%h beats=%0d err=%b exp v=1 y=01 beats=3 err=0",
                      bus.out_valid, bus.y, bus.beats, bus.err);
    end
    drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    step();
  endtask

  task automatic test_forced_close();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 8'(1 << k), 8'h00, 3'd0, (k == 2) ? 1'b0 : 1'b1, 1'b0);
      step();
      if (k < 3) begin
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL forced_early_valid beat%0d got=%b exp=0", k, bus.out_valid); end
      end
    end
    total++;
    if (bus.out_valid !== 1'b1 || bus.y !== 8'h0F || bus.beats !== CNT_W'(4) || bus.err !== 1'b1) begin
      bad++; $display("FAIL forced_result got v=%b y=%h beats=%0d err=%b exp v=1 y=0F beats=4 err=1",
                      bus.out_valid, bus.y, bus.beats, bus.err);
    end
    drive(1'b1, 8'h3C, 8'h00, 3'd1, 1'b1, 1'b1);
    step();
    total++;
    if (bus.y !== 8'h3C || bus.beats !== CNT_W'(1) || bus.err !== 1'b0) begin
      bad++; $display("FAIL forced_next_frame got y=%h beats=%0d err=%b exp y=3C beats=1 err=0", bus.y, bus.beats, bus.err);
    end
    drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    step();
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    drive(1'b1, 8'hA5, 8'h0F, 3'd5, 1'b0, 1'b0);
    step();
    drive(1'b1, 8'h12, 8'h34, 3'd0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step();
      total++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.y !== 8'hAA) begin
        bad++; $display("FAIL stall_cycle%0d got rdy=%b v=%b y=%h exp rdy=0 v=1 y=AA", k, bus.in_ready, bus.out_valid, bus.y);
      end
    end
    bus.out_ready = 1'b1;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL stall_release_ready got=%b exp=1", bus.in_ready); end
    step();
    drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    total++;
    if (bus.out_valid !== 1'b1 || bus.y !== 8'h36) begin
      bad++; $display("FAIL stall_no_bubble got v=%b y=%h exp v=1 y=36", bus.out_valid, bus.y);
    end
    step();
  endtask

  task automatic test_reset_mid_frame();
    drive(1'b1, 8'h0F, 8'h00, 3'd1, 1'b1, 1'b0);
    step();
    drive(1'b1, 8'h3C, 8'h00, 3'd1, 1'b1, 1'b0);
    step();
    drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    do_reset();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL midreset_valid got=%b exp=0", bus.out_valid); end
    drive(1'b1, 8'hAA, 8'h00, 3'd1, 1'b1, 1'b1);
    step();
    drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    total++;
    if (bus.out_valid !== 1'b1 || bus.y !== 8'hAA || bus.beats !== CNT_W'(1)) begin
      bad++; $display("FAIL midreset_frame got v=%b y=%h beats=%0d exp v=1 y=AA beats=1", bus.out_valid, bus.y, bus.beats);
    end
    step();
  endtask

  task automatic test_random();
    logic       iv, imode, ilast, ior;
    logic [7:0] ia, ib;
    logic [2:0] iop;
    drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    do_reset();
    m_y = 8'h00; m_ov = 1'b0; m_beats = 0; m_err = 1'b0; m_open = 1'b0; m_fop = 3'd0; fq.delete();
    for (int n = 0; n < 600; n++) begin
      iv    = ($urandom_range(0, 3) != 0);
      ia    = 8'($urandom);
      ib    = 8'($urandom);
      iop   = 3'($urandom_range(0, 7));
      imode = 1'($urandom_range(0, 1));
      ilast = ($urandom_range(0, 2) == 0);
      ior   = ($urandom_range(0, 3) != 0);
      drive(iv, ia, ib, iop, imode, ilast);
      bus.out_ready = ior;
      #1;
      total++;
      if (bus.in_ready !== (!m_ov || ior)) begin
        bad++; $display("FAIL rand_in_ready cyc%0d got=%b exp=%b", n, bus.in_ready, !m_ov || ior);
      end
      @(posedge clk);
      model_edge(iv, ia, ib, iop, imode, ilast, ior);
      #1;
      total++;
      if (bus.out_valid !== m_ov || bus.y !== m_y || bus.beats !== CNT_W'(m_beats) || bus.err !== m_err ||
          bus.y_any !== (m_y != 8'h00) || bus.y_all !== (m_y == 8'hFF)) begin
        bad++; $display("FAIL rand_out cyc%0d got v=%b y=%h beats=%0d err=%b any=%b all=%b exp v=%b y=%h beats=%0d err=%b",
                        n, bus.out_valid, bus.y, bus.beats, bus.err, bus.y_any, bus.y_all, m_ov, m_y, m_beats, m_err);
      end
    end
    drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_pairwise_sweep();
    test_accum_xnor();
    test_forced_close();
    test_backpressure();
    test_reset_mid_frame();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/logic_gate_unit.md
# logic_gate_unit

Parametrised, registered logic-gate engine that applies one of eight bitwise gate functions to WIDTH-bit operands, either per beat (pairwise mode) or folded across a multi-beat frame (accumulate mode). Input and output each use a valid/ready handshake, so the block drops into any streaming datapath in the design as a drop-in logic stage.

## Interface
- WIDTH, 8, operand/result width in bits (≥1)
- MAX_BEATS, 16, maximum beats per accumulate frame (≥2)
- CNT_W, $clog2(MAX_BEATS+1), beat counter width
- clk  input  1  rising-edge clock; single clock domain
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input beat offered
- in_ready  output  1  input beat accepted when in_valid && in_ready
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B (pairwise mode only)
- op  input  3  0 OR, 1 AND, 2 NOT-A, 3 NOR, 4 NAND, 5 XOR, 6 XNOR, 7 BUF-A
- mode  input  1  0 pairwise, 1 accumulate
- last  input  1  final beat of an accumulate frame (ignored in pairwise)
- out_valid  output  1  result held in output register
- out_ready  input  1  downstream accepts result
- y  output  WIDTH  result
- y_any  output  1  OR-reduction of y
- y_all  output  1  AND-reduction of y
- beats  output  CNT_W  beats folded into y (1 in pairwise)
- err  output  1  frame force-closed at MAX_BEATS without last

## Operation
- Accept: in_ready = !out_valid || out_ready, identical in both modes and states.
- Pairwise (mode=0), per accepted beat: y <= f(a,b); NOT-A → ~a, BUF-A → a; beats <= 1; err <= 0; out_valid <= 1.
- Accumulate (mode=1): states IDLE, ACCUM.
  - IDLE, beat accepted with mode=1: latch op and mode into frame registers; acc <= a; cnt <= 1. If last → emit, stay IDLE; else → ACCUM.
  - ACCUM, beat accepted: op/mode inputs ignored (frame values used); acc <= g(acc,a), where g is OR for OR/NOR, AND for AND/NAND, XOR for XOR/XNOR, replace (acc <= a) for NOT-A/BUF-A; cnt <= cnt+1.
  - Emit when last is set, or when cnt+1 = MAX_BEATS (forced close, err <= 1); → IDLE.
  - Emit: y <= acc_next, inverted for NOR, NAND, XNOR, NOT-A; beats <= cnt_next; out_valid <= 1.
  - Non-final accumulate beats never alter y, out_valid, beats or err.
- A beat with mode=0 while in ACCUM is treated as part of the open frame (frame mode governs until close).
- y_any/y_all are combinational from the y register.
- out_valid clears on out_ready unless a new result loads in the same cycle (back-to-back, no bubble).

## Timing
- Reset (async assert, sync-safe deassert): out_valid=0, y=0, beats=0, err=0, state IDLE, acc=0, cnt=0; y_any=0, y_all=0 (WIDTH≥1).
- Pairwise latency: result registered on the accepting edge, out_valid high the next cycle; throughput 1 beat/cycle with out_ready=1.
- Accumulate latency: result valid the cycle after the accepting edge of the final beat.
- Stall: out_valid && !out_ready → in_ready=0; y, beats, err, out_valid held stable.
- Simultaneous out_ready and final beat: old result leaves, new result loads in the same edge.
- Reset mid-frame discards acc and cnt; no partial result is emitted.
- cnt never exceeds MAX_BEATS; err reflects only the currently held result.

## Test plan
- Reset: hold rst_n=0 while driving beats → out_valid=0, y=8'h00, in_ready=1 after release; y_all=0.
- Pairwise sweep: a=8'hC5, b=8'h3A, op 0..7 back-to-back, out_ready=1 → y = FF,00,3A,00,FF,FF,00,C5 on consecutive cycles, beats=1.
- Accumulate XNOR: beats a=8'h0F, 8'hF0, 8'h01 (last) → single result y=8'h01 (~(0F^F0^01)=~FE), beats=3, err=0; no out_valid during earlier beats.
- Forced close: MAX_BEATS=4, op=OR, a=8'h01,02,04,08 without last → y=8'h0F, beats=4, err=1; next beat starts a new frame.
- Backpressure: out_ready=0 for 5 cycles after a result → in_ready=0, y stable; raise out_ready with a pending beat → new result loads with no bubble cycle.
- Reset mid-frame: two AND beats then rst_n pulse, then a one-beat frame a=8'hAA last → y=8'hAA, beats=1.
